// File: rtl/ctrl_pkg.sv
// Shared encodings for the AOC multicycle control unit: opcodes, FSM states,
// datapath select codes and the control word driven onto the datapath.
package ctrl_pkg;

  localparam logic [7:0] OPC_R    = 8'h00;
  localparam logic [7:0] OPC_ADDI = 8'h01;
  localparam logic [7:0] OPC_STI  = 8'h09;
  localparam logic [7:0] OPC_LDI  = 8'h0A;
  localparam logic [7:0] OPC_STR  = 8'h0B;
  localparam logic [7:0] OPC_LDR  = 8'h0C;
  localparam logic [7:0] OPC_BEQ  = 8'h0D;
  localparam logic [7:0] OPC_BNE  = 8'h0E;
  localparam logic [7:0] OPC_BLT  = 8'h0F;
  localparam logic [7:0] OPC_BGT  = 8'h10;
  localparam logic [7:0] OPC_HLT  = 8'h12;
  localparam logic [7:0] OPC_IN   = 8'h13;
  localparam logic [7:0] OPC_OUT  = 8'h14;
  localparam logic [7:0] OPC_JMP  = 8'h15;
  localparam logic [7:0] OPC_JAL  = 8'h16;
  localparam logic [7:0] OPC_JST  = 8'h17;
  localparam logic [7:0] OPC_LSTK = 8'h1C;
  localparam logic [7:0] OPC_SSTK = 8'h1D;

  typedef enum logic [4:0] {
    ST_FETCH    = 5'd0,  ST_DECODE   = 5'd1,  ST_ADDR     = 5'd2,  ST_MEM_RD   = 5'd3,
    ST_WB_MEM   = 5'd4,  ST_MEM_WR   = 5'd5,  ST_EXEC_R   = 5'd6,  ST_EXEC_I   = 5'd7,
    ST_WB_ALU   = 5'd8,  ST_BR_CALC  = 5'd9,  ST_BR_UPD   = 5'd10, ST_JMP      = 5'd11,
    ST_IN_WAIT  = 5'd12, ST_OUT_WAIT = 5'd13, ST_STK_RD   = 5'd14, ST_STK_PUSH = 5'd15,
    ST_STK_LD   = 5'd16, ST_STK_POP  = 5'd17, ST_HALT     = 5'd18
  } state_e;

  typedef enum logic [1:0] {PC_ALU = 2'b00, PC_ALUOUT = 2'b01, PC_BRANCH = 2'b10, PC_STACK = 2'b11} pc_sel_e;
  typedef enum logic [1:0] {B_REG = 2'b00, B_ONE = 2'b01, B_IMM = 2'b11} alu_b_sel_e;
  typedef enum logic [1:0] {ALU_FUNCT = 2'b00, ALU_ADD = 2'b01, ALU_SUB = 2'b10, ALU_IMM = 2'b11} alu_op_e;

  typedef struct packed {
    logic       pc_we, ir_we, reg_we, mem_we, push, pop;
    pc_sel_e    pc_sel;
    logic       alu_a_sel;
    alu_b_sel_e alu_b_sel;
    logic       addr_sel, wdata_sel, reg_wsel, in_sel, stk_sel;
    alu_op_e    alu_op;
    logic       halted, io_timeout, in_ready, out_valid;
  } ctrl_t;

  // Wide enough to hold the larger wait limit plus one saturated count above it.
  function automatic int cnt_width(input int mem_lat, input int io_timeout);
    int top;
    top = (mem_lat > io_timeout) ? mem_lat : io_timeout;
    return $clog2(top + 2);
  endfunction

endpackage

// File: rtl/ctrl_fsm_hs_if.sv
// Control-unit bundle: IR opcode, flags and I/O handshakes in, datapath
// selects and write enables out. master = control unit, slave = datapath side.
interface ctrl_fsm_hs_if #(
  parameter int OP_W    = 6,
  parameter int STATE_W = 5
);
  logic [OP_W-1:0]    opcode;
  logic               zero, in_valid, in_ready, out_valid, out_ready, resume;
  logic [STATE_W-1:0] state;
  logic               pc_we, ir_we, reg_we, mem_we, push, pop;
  logic [1:0]         pc_sel;
  logic               alu_a_sel;
  logic [1:0]         alu_b_sel;
  logic               addr_sel, wdata_sel, reg_wsel, in_sel, stk_sel;
  logic [1:0]         alu_op;
  logic               halted, io_timeout;

  modport master (
    input  opcode, zero, in_valid, out_ready, resume,
    output state, in_ready, out_valid, pc_we, ir_we, reg_we, mem_we, push, pop,
           pc_sel, alu_a_sel, alu_b_sel, addr_sel, wdata_sel, reg_wsel, in_sel,
           stk_sel, alu_op, halted, io_timeout
  );

  modport slave (
    output opcode, zero, in_valid, out_ready, resume,
    input  state, in_ready, out_valid, pc_we, ir_we, reg_we, mem_we, push, pop,
           pc_sel, alu_a_sel, alu_b_sel, addr_sel, wdata_sel, reg_wsel, in_sel,
           stk_sel, alu_op, halted, io_timeout
  );
endinterface

// File: rtl/ctrl_wait_cnt.sv
// Clearable saturating cycle counter with a terminal-count compare, shared by
// the memory wait states and the I/O handshake timeout.
module ctrl_wait_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic [W-1:0] limit_i,
  output logic         tc_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)              cnt_d = '0;
    else if (cnt_q != '1)   cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == limit_i);
endmodule

// File: rtl/ctrl_fsm_hs.sv
// Multicycle control FSM for the AOC datapath: Moore decode of state/opcode
// into mux selects and write enables, with memory waits, I/O handshakes and halt.
module ctrl_fsm_hs
  import ctrl_pkg::*;
#(
  parameter int OP_W       = 6,
  parameter int MEM_LAT    = 1,
  parameter int IO_TIMEOUT = 0,
  parameter int STATE_W    = 5
) (
  input  logic          clk,
  input  logic          reset,
  ctrl_fsm_hs_if.master bus
);
  localparam int               CNT_W    = cnt_width(MEM_LAT, IO_TIMEOUT);
  localparam logic [CNT_W-1:0] MEM_LIM  = CNT_W'(MEM_LAT);
  localparam logic [CNT_W-1:0] IO_LIM   = CNT_W'((IO_TIMEOUT > 0) ? IO_TIMEOUT - 1 : 0);
  localparam bit               IO_TO_EN = (IO_TIMEOUT > 0);

  state_e state_q, state_d, cur_s;
  ctrl_t  ctl;
  logic   cnt_clr, cnt_tc, io_abort;
  logic   op_r, op_load, op_store, op_imm_addr, op_br, op_jmp, op_jal, op_jst;
  logic   op_in, op_out, op_lstk, op_sstk, op_hlt;

  function automatic logic op_is(input logic [OP_W-1:0] op, input logic [7:0] code);
    return op == OP_W'(code);
  endfunction

  assign op_r        = op_is(bus.opcode, OPC_R);
  assign op_load     = op_is(bus.opcode, OPC_LDI) | op_is(bus.opcode, OPC_LDR);
  assign op_store    = op_is(bus.opcode, OPC_STI) | op_is(bus.opcode, OPC_STR);
  assign op_imm_addr = op_is(bus.opcode, OPC_STI) | op_is(bus.opcode, OPC_LDI);
  assign op_br       = op_is(bus.opcode, OPC_BEQ) | op_is(bus.opcode, OPC_BNE) |
                       op_is(bus.opcode, OPC_BLT) | op_is(bus.opcode, OPC_BGT);
  assign op_jmp      = op_is(bus.opcode, OPC_JMP);
  assign op_jal      = op_is(bus.opcode, OPC_JAL);
  assign op_jst      = op_is(bus.opcode, OPC_JST);
  assign op_in       = op_is(bus.opcode, OPC_IN);
  assign op_out      = op_is(bus.opcode, OPC_OUT);
  assign op_lstk     = op_is(bus.opcode, OPC_LSTK);
  assign op_sstk     = op_is(bus.opcode, OPC_SSTK);
  assign op_hlt      = op_is(bus.opcode, OPC_HLT);

  // Reset decodes as FETCH in the same cycle, so an interrupted wait issues no write or handshake.
  assign cur_s    = reset ? ST_FETCH : state_q;
  assign cnt_clr  = (state_d != cur_s);
  assign io_abort = IO_TO_EN && cnt_tc;

  ctrl_wait_cnt #(.W(CNT_W)) u_wait_cnt (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (cnt_clr),
    .limit_i ((cur_s == ST_MEM_RD || cur_s == ST_MEM_WR) ? MEM_LIM : IO_LIM),
    .tc_o    (cnt_tc)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d = cur_s;
    ctl     = '0;
    case (cur_s)
      ST_FETCH: begin
        ctl.ir_we = 1'b1; ctl.alu_b_sel = B_ONE; ctl.alu_op = ALU_ADD; ctl.in_sel = 1'b1;
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        ctl.pc_we = !op_hlt;
        if (op_r)                      state_d = ST_EXEC_R;
        else if (op_load || op_store)  state_d = ST_ADDR;
        else if (op_br)                state_d = ST_BR_CALC;
        else if (op_jmp || op_jal)     state_d = ST_JMP;
        else if (op_jst)               state_d = ST_BR_UPD;
        else if (op_in)                state_d = ST_IN_WAIT;
        else if (op_out)               state_d = ST_OUT_WAIT;
        else if (op_lstk)              state_d = ST_STK_RD;
        else if (op_sstk)              state_d = ST_STK_LD;
        else if (op_hlt)               state_d = ST_HALT;
        else                           state_d = ST_EXEC_I;
      end
      ST_ADDR: begin
        ctl.alu_a_sel = 1'b1; ctl.alu_b_sel = B_IMM; ctl.addr_sel = 1'b1;
        ctl.alu_op    = op_imm_addr ? ALU_IMM : ALU_ADD;
        state_d       = op_load ? ST_MEM_RD : ST_MEM_WR;
      end
      ST_MEM_RD: if (cnt_tc) state_d = ST_WB_MEM;
      ST_WB_MEM: begin
        ctl.reg_we = 1'b1; ctl.reg_wsel = 1'b1;
        state_d = ST_FETCH;
      end
      ST_MEM_WR: begin
        ctl.mem_we = 1'b1; ctl.wdata_sel = op_sstk;
        if (cnt_tc) state_d = op_sstk ? ST_STK_POP : ST_FETCH;
      end
      ST_EXEC_R: begin
        ctl.alu_a_sel = 1'b1;
        state_d = ST_WB_ALU;
      end
      ST_EXEC_I: begin
        ctl.alu_a_sel = 1'b1; ctl.alu_b_sel = B_IMM;
        state_d = ST_WB_ALU;
      end
      ST_WB_ALU: begin
        ctl.reg_we = 1'b1;
        state_d = ST_FETCH;
      end
      ST_BR_CALC: begin
        ctl.pc_sel = PC_ALUOUT; ctl.alu_a_sel = 1'b1;
        state_d = ST_BR_UPD;
      end
      ST_BR_UPD: begin
        ctl.pc_we  = op_jst | bus.zero;
        ctl.pop    = op_jst;
        ctl.pc_sel = op_jst ? PC_STACK : PC_BRANCH;
        state_d    = ST_FETCH;
      end
      ST_JMP: begin
        ctl.pc_we = 1'b1; ctl.alu_op = ALU_IMM; ctl.alu_b_sel = B_IMM; ctl.push = op_jal;
        state_d = ST_FETCH;
      end
      ST_IN_WAIT: begin
        ctl.in_ready = 1'b1; ctl.in_sel = 1'b1; ctl.reg_we = bus.in_valid;
        if (bus.in_valid)  state_d = ST_FETCH;
        else if (io_abort) begin ctl.io_timeout = 1'b1; state_d = ST_FETCH; end
      end
      ST_OUT_WAIT: begin
        ctl.out_valid = 1'b1;
        if (bus.out_ready) state_d = ST_FETCH;
        else if (io_abort) begin ctl.io_timeout = 1'b1; state_d = ST_FETCH; end
      end
      ST_STK_RD: begin
        ctl.stk_sel = 1'b1; ctl.alu_a_sel = 1'b1;
        state_d = ST_STK_PUSH;
      end
      ST_STK_PUSH: begin
        ctl.push = 1'b1;
        state_d = ST_FETCH;
      end
      ST_STK_LD: begin
        ctl.addr_sel = 1'b1; ctl.wdata_sel = 1'b1;
        state_d = ST_MEM_WR;
      end
      ST_STK_POP: begin
        ctl.pop = 1'b1;
        state_d = ST_FETCH;
      end
      ST_HALT: begin
        ctl.halted = 1'b1;
        if (bus.resume) state_d = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_FETCH;
    else       state_q <= state_d;
  end

  assign bus.state      = STATE_W'(cur_s);
  assign bus.pc_we      = ctl.pc_we;
  assign bus.ir_we      = ctl.ir_we;
  assign bus.reg_we     = ctl.reg_we;
  assign bus.mem_we     = ctl.mem_we;
  assign bus.push       = ctl.push;
  assign bus.pop        = ctl.pop;
  assign bus.pc_sel     = ctl.pc_sel;
  assign bus.alu_a_sel  = ctl.alu_a_sel;
  assign bus.alu_b_sel  = ctl.alu_b_sel;
  assign bus.addr_sel   = ctl.addr_sel;
  assign bus.wdata_sel  = ctl.wdata_sel;
  assign bus.reg_wsel   = ctl.reg_wsel;
  assign bus.in_sel     = ctl.in_sel;
  assign bus.stk_sel    = ctl.stk_sel;
  assign bus.alu_op     = ctl.alu_op;
  assign bus.halted     = ctl.halted;
  assign bus.io_timeout = ctl.io_timeout;
  assign bus.in_ready   = ctl.in_ready;
  assign bus.out_valid  = ctl.out_valid;
endmodule

// File: tb/tb_ctrl_fsm_hs.sv
// Bench for ctrl_fsm_hs: two configurations (slow memory / no timeout, fast
// memory / 8-cycle timeout) checked cycle by cycle against an instruction-level model.
module tb_ctrl_fsm_hs;
  import ctrl_pkg::*;

  localparam int OP_W = 6, STATE_W = 5;
  localparam int LAT_A = 3, TO_A = 0;
  localparam int LAT_B = 1, TO_B = 8;
  localparam int RND = -1;
  localparam int NEVER = 1000;

  typedef struct packed {
    logic [4:0] state;
    logic       pc_we, ir_we, reg_we, mem_we, push, pop;
    logic [1:0] pc_sel;
    logic       alu_a_sel;
    logic [1:0] alu_b_sel;
    logic       addr_sel, wdata_sel, reg_wsel, in_sel, stk_sel;
    logic [1:0] alu_op;
    logic       halted, io_timeout, in_ready, out_valid;
  } cw_t;

  typedef enum {K_R, K_IMM, K_LOAD, K_STORE, K_BR, K_JMP, K_JAL, K_JST,
                K_IN, K_OUT, K_LSTK, K_SSTK, K_HLT} kind_e;

  logic clk = 1'b0;
  logic reset, sel;
  logic [OP_W-1:0] opcode;
  logic zero, in_valid, out_ready, resume;
  int   vectors = 0, miscompares = 0;
  cw_t  obs_a, obs_b, obs;

  ctrl_fsm_hs_if #(.OP_W(OP_W), .STATE_W(STATE_W)) if_a ();
  ctrl_fsm_hs_if #(.OP_W(OP_W), .STATE_W(STATE_W)) if_b ();

  // The inactive configuration is parked in reset, so it idles at FETCH.
  ctrl_fsm_hs #(.OP_W(OP_W), .MEM_LAT(LAT_A), .IO_TIMEOUT(TO_A), .STATE_W(STATE_W))
    dut_a (.clk(clk), .reset(reset | sel), .bus(if_a.master));
  ctrl_fsm_hs #(.OP_W(OP_W), .MEM_LAT(LAT_B), .IO_TIMEOUT(TO_B), .STATE_W(STATE_W))
    dut_b (.clk(clk), .reset(reset | ~sel), .bus(if_b.master));

  always #5 clk = ~clk;

  assign if_a.opcode = opcode;    assign if_b.opcode = opcode;
  assign if_a.zero = zero;        assign if_b.zero = zero;
  assign if_a.in_valid = in_valid;   assign if_b.in_valid = in_valid;
  assign if_a.out_ready = out_ready; assign if_b.out_ready = out_ready;
  assign if_a.resume = resume;    assign if_b.resume = resume;

  assign obs_a = {if_a.state, if_a.pc_we, if_a.ir_we, if_a.reg_we, if_a.mem_we, if_a.push, if_a.pop,
                  if_a.pc_sel, if_a.alu_a_sel, if_a.alu_b_sel, if_a.addr_sel, if_a.wdata_sel,
                  if_a.reg_wsel, if_a.in_sel, if_a.stk_sel, if_a.alu_op, if_a.halted,
                  if_a.io_timeout, if_a.in_ready, if_a.out_valid};
  assign obs_b = {if_b.state, if_b.pc_we, if_b.ir_we, if_b.reg_we, if_b.mem_we, if_b.push, if_b.pop,
                  if_b.pc_sel, if_b.alu_a_sel, if_b.alu_b_sel, if_b.addr_sel, if_b.wdata_sel,
                  if_b.reg_wsel, if_b.in_sel, if_b.stk_sel, if_b.alu_op, if_b.halted,
                  if_b.io_timeout, if_b.in_ready, if_b.out_valid};
  assign obs = sel ? obs_b : obs_a;

  function automatic cw_t w(input state_e s);
    cw_t c;
    c = '0;
    c.state = s;
    return c;
  endfunction

  function automatic cw_t fetch_word();
    cw_t c;
    c = w(ST_FETCH);
    c.ir_we = 1'b1; c.alu_b_sel = 2'b01; c.alu_op = 2'b01; c.in_sel = 1'b1;
    return c;
  endfunction

  function automatic kind_e kind_of(input logic [OP_W-1:0] op);
    case (8'(op))
      OPC_R:                               return K_R;
      OPC_LDI, OPC_LDR:                    return K_LOAD;
      OPC_STI, OPC_STR:                    return K_STORE;
      OPC_BEQ, OPC_BNE, OPC_BLT, OPC_BGT:  return K_BR;
      OPC_JMP:                             return K_JMP;
      OPC_JAL:                             return K_JAL;
      OPC_JST:                             return K_JST;
      OPC_IN:                              return K_IN;
      OPC_OUT:                             return K_OUT;
      OPC_LSTK:                            return K_LSTK;
      OPC_SSTK:                            return K_SSTK;
      OPC_HLT:                             return K_HLT;
      default:                             return K_IMM;
    endcase
  endfunction

  // One clock: drive inputs (RND = don't care, randomised), compare at negedge, advance.
  task automatic step(input cw_t exp, input int iv, input int ordy, input int rs, input int zr,
                      input string tag);
    in_valid  = (iv   < 0) ? 1'($urandom_range(1)) : 1'(iv);
    out_ready = (ordy < 0) ? 1'($urandom_range(1)) : 1'(ordy);
    resume    = (rs   < 0) ? 1'($urandom_range(1)) : 1'(rs);
    zero      = (zr   < 0) ? 1'($urandom_range(1)) : 1'(zr);
    @(negedge clk);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s (vector %0d, cfg %0d): observed %h expected %h", tag, vectors, sel, obs, exp);
    end
    @(posedge clk);
    #1;
  endtask

  // Instruction-level reference: expected control word sequence from FETCH to the last cycle.
  // hs_at = index of the wait cycle on which in_valid/out_ready/resume is raised.
  task automatic run_instr(input logic [7:0] op8, input logic z, input int hs_at, input string tag);
    kind_e k;
    cw_t   e;
    int    lat, to;
    opcode = OP_W'(op8);
    k   = kind_of(opcode);
    lat = sel ? LAT_B : LAT_A;
    to  = sel ? TO_B : TO_A;
    step(fetch_word(), RND, RND, RND, RND, tag);
    e = w(ST_DECODE); e.pc_we = (k != K_HLT);
    step(e, RND, RND, RND, RND, tag);
    case (k)
      K_R, K_IMM: begin
        e = w(k == K_R ? ST_EXEC_R : ST_EXEC_I); e.alu_a_sel = 1'b1;
        if (k == K_IMM) e.alu_b_sel = 2'b11;
        step(e, RND, RND, RND, RND, tag);
        e = w(ST_WB_ALU); e.reg_we = 1'b1;
        step(e, RND, RND, RND, RND, tag);
      end
      K_LOAD, K_STORE: begin
        e = w(ST_ADDR); e.alu_a_sel = 1'b1; e.alu_b_sel = 2'b11; e.addr_sel = 1'b1;
        e.alu_op = (op8 == OPC_LDI || op8 == OPC_STI) ? 2'b11 : 2'b01;
        step(e, RND, RND, RND, RND, tag);
        for (int i = 0; i <= lat; i++) begin
          e = w(k == K_LOAD ? ST_MEM_RD : ST_MEM_WR);
          e.mem_we = (k == K_STORE);
          step(e, RND, RND, RND, RND, tag);
        end
        if (k == K_LOAD) begin
          e = w(ST_WB_MEM); e.reg_we = 1'b1; e.reg_wsel = 1'b1;
          step(e, RND, RND, RND, RND, tag);
        end
      end
      K_BR: begin
        e = w(ST_BR_CALC); e.pc_sel = 2'b01; e.alu_a_sel = 1'b1;
        step(e, RND, RND, RND, RND, tag);
        e = w(ST_BR_UPD); e.pc_we = z; e.pc_sel = 2'b10;
        step(e, RND, RND, RND, int'(z), tag);
      end
      K_JST: begin
        e = w(ST_BR_UPD); e.pc_we = 1'b1; e.pop = 1'b1; e.pc_sel = 2'b11;
        step(e, RND, RND, RND, RND, tag);
      end
      K_JMP, K_JAL: begin
        e = w(ST_JMP); e.pc_we = 1'b1; e.alu_op = 2'b11; e.alu_b_sel = 2'b11; e.push = (k == K_JAL);
        step(e, RND, RND, RND, RND, tag);
      end
      K_IN, K_OUT: begin
        for (int c = 0; c <= hs_at; c++) begin
          e = w(k == K_IN ? ST_IN_WAIT : ST_OUT_WAIT);
          if (k == K_IN) begin e.in_ready = 1'b1; e.in_sel = 1'b1; end
          else           e.out_valid = 1'b1;
          if (c == hs_at) begin
            e.reg_we = (k == K_IN);
            step(e, (k == K_IN) ? 1 : RND, (k == K_OUT) ? 1 : RND, RND, RND, tag);
          end else if (to > 0 && c == to - 1) begin
            e.io_timeout = 1'b1;
            step(e, (k == K_IN) ? 0 : RND, (k == K_OUT) ? 0 : RND, RND, RND, tag);
            break;
          end else begin
            step(e, (k == K_IN) ? 0 : RND, (k == K_OUT) ? 0 : RND, RND, RND, tag);
          end
        end
      end
      K_LSTK: begin
        e = w(ST_STK_RD); e.stk_sel = 1'b1; e.alu_a_sel = 1'b1;
        step(e, RND, RND, RND, RND, tag);
        e = w(ST_STK_PUSH); e.push = 1'b1;
        step(e, RND, RND, RND, RND, tag);
      end
      K_SSTK: begin
        e = w(ST_STK_LD); e.addr_sel = 1'b1; e.wdata_sel = 1'b1;
        step(e, RND, RND, RND, RND, tag);
        for (int i = 0; i <= lat; i++) begin
          e = w(ST_MEM_WR); e.mem_we = 1'b1; e.wdata_sel = 1'b1;
          step(e, RND, RND, RND, RND, tag);
        end
        e = w(ST_STK_POP); e.pop = 1'b1;
        step(e, RND, RND, RND, RND, tag);
      end
      K_HLT: begin
        for (int c = 0; c <= hs_at; c++) begin
          e = w(ST_HALT); e.halted = 1'b1;
          step(e, RND, RND, (c == hs_at) ? 1 : 0, RND, tag);
        end
      end
      default: ;
    endcase
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rop;
    kind_e      rk;
    cw_t        e;
    opcode = '0; zero = 1'b0; in_valid = 1'b0; out_ready = 1'b0; resume = 1'b0;
    sel = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    step(fetch_word(), RND, RND, RND, RND, "reset_a");
    step(fetch_word(), 1, 1, 1, RND, "reset_hold");
    reset = 1'b0;

    // Configuration A: MEM_LAT=3, no I/O timeout.
    run_instr(OPC_LDI, 1'b0, 0, "ldi_lat3");
    run_instr(OPC_STR, 1'b0, 0, "str_lat3");
    run_instr(OPC_IN, 1'b0, 20, "in_wait20");
    run_instr(OPC_SSTK, 1'b0, 0, "sstk_lat3");
    run_instr(OPC_HLT, 1'b0, 4, "hlt_resume");

    // Reset while waiting for input: no write, FETCH immediately.
    opcode = OP_W'(OPC_IN);
    step(fetch_word(), RND, RND, RND, RND, "rst_in_fetch");
    e = w(ST_DECODE); e.pc_we = 1'b1;
    step(e, RND, RND, RND, RND, "rst_in_decode");
    e = w(ST_IN_WAIT); e.in_ready = 1'b1; e.in_sel = 1'b1;
    for (int i = 0; i < 3; i++) step(e, 0, RND, RND, RND, "rst_in_wait");
    reset = 1'b1;
    step(fetch_word(), 1, RND, RND, RND, "rst_in_abort");
    reset = 1'b0;
    run_instr(OPC_R, 1'b0, 0, "after_reset");

    // Configuration B: MEM_LAT=1, IO_TIMEOUT=8.
    sel = 1'b1;
    run_instr(OPC_R, 1'b0, 0, "add_r");
    run_instr(OPC_OUT, 1'b0, NEVER, "out_timeout");
    run_instr(OPC_OUT, 1'b0, 7, "out_hs_at_limit");
    run_instr(OPC_IN, 1'b0, NEVER, "in_timeout");
    run_instr(OPC_IN, 1'b0, 3, "in_hs3");
    run_instr(OPC_BEQ, 1'b0, 0, "beq_z0");
    run_instr(OPC_BEQ, 1'b1, 0, "beq_z1");
    run_instr(OPC_JST, 1'b0, 0, "jst");
    run_instr(OPC_JAL, 1'b0, 0, "jal");
    run_instr(OPC_JMP, 1'b0, 0, "jmp");
    run_instr(OPC_LSTK, 1'b0, 0, "lstk");
    run_instr(OPC_SSTK, 1'b0, 0, "sstk_lat1");
    run_instr(OPC_LDR, 1'b0, 0, "ldr_lat1");
    run_instr(OPC_STI, 1'b0, 0, "sti_lat1");
    run_instr(OPC_ADDI, 1'b0, 0, "addi");
    run_instr(8'h3F, 1'b0, 0, "undef_op");

    // Randomised instruction stream across both configurations.
    for (int n = 0; n < 120; n++) begin
      sel = 1'($urandom_range(1));
      rop = 8'($urandom_range(63));
      if (n % 3 == 0) begin
        case ($urandom_range(5))
          0: rop = OPC_IN;   1: rop = OPC_OUT;  2: rop = OPC_HLT;
          3: rop = OPC_SSTK; 4: rop = OPC_BNE;  default: rop = OPC_LDR;
        endcase
      end
      rk = kind_of(OP_W'(rop));
      run_instr(rop, 1'($urandom_range(1)),
                (rk == K_HLT) ? int'($urandom_range(6)) : int'($urandom_range(12)), "random");
    end
    step(fetch_word(), RND, RND, RND, RND, "final_fetch");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ctrl_fsm_hs.md
Name: ctrl_fsm_hs

Overview:
Parametrised multicycle control unit for the AOC processor datapath, the next-generation replacement for the single-edge-pair FSM.
- Single posedge state register; Moore outputs decoded combinationally from state and opcode.
- Push-button I/O replaced by valid/ready handshakes, with an optional timeout.
- Configurable memory wait states.
- Halt state with a resume input.
- Sits between the instruction register and all datapath mux/write-enable inputs; ALU function decode stays in the separate ALU control block, driven by alu_op.

Parameters:
OP_W, 6, opcode width.
MEM_LAT, 1, extra wait cycles for a memory read or write (0..15).
IO_TIMEOUT, 0, handshake wait limit in cycles; 0 = wait forever.
STATE_W, 5, state register width.

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
opcode  in  OP_W  IR opcode field
zero  in  1  ALU branch-condition flag
in_valid  in  1  input device has data
in_ready  out  1  core accepting input data
out_valid  out  1  core presenting output data
out_ready  in  1  output device accepted data
resume  in  1  leave HALT
state  out  STATE_W  current state (debug)
pc_we, ir_we, reg_we, mem_we  out  1 each  write enables
push, pop  out  1 each  return/data stack strobes
pc_sel  out  2  00 ALU, 01 ALUOut, 10 branch target, 11 stack top
alu_a_sel  out  1  0 PC, 1 regA
alu_b_sel  out  2  00 regB, 01 const 1, 11 immediate
addr_sel, wdata_sel, reg_wsel, in_sel, stk_sel  out  1 each  datapath mux selects
alu_op  out  2  to ALU control
halted  out  1  high in HALT
io_timeout  out  1  one-cycle pulse on handshake abort

Behaviour:
- Reset: reset is synchronous, active-high; clock is clk. On reset, state=FETCH and the wait counter is 0. Every output is the FETCH decode: ir_we=1, alu_b_sel=01, alu_op=01, in_sel=1; all other outputs 0.
- One state per clock. Outputs follow the state in the same cycle; there is no negedge logic.
- FETCH -> DECODE.
- DECODE:
  - pc_we=1 unless opcode is hlt.
  - Dispatch: R -> EXEC_R; sti/ldi/str/ldr -> ADDR; beq/bne/blt/bgt -> BR_CALC; jmp/jal -> JMP; jst -> BR_UPD; in -> IN_WAIT; out -> OUT_WAIT; lstk -> STK_RD; sstk -> STK_LD; hlt -> HALT; anything else -> EXEC_I.
- ADDR: alu_a_sel=1, alu_b_sel=11, addr_sel=1; alu_op=11 for sti/ldi, 01 otherwise. Loads -> MEM_RD; stores -> MEM_WR.
- MEM_RD: counter counts MEM_LAT cycles (stays MEM_LAT+1 cycles total) -> WB_MEM.
- WB_MEM: reg_we=1, reg_wsel=1 -> FETCH.
- MEM_WR: mem_we=1 held MEM_LAT+1 cycles; wdata_sel=1 for sstk -> FETCH.
- EXEC_R: alu_a_sel=1 -> WB_ALU. EXEC_I: alu_a_sel=1, alu_b_sel=11 -> WB_ALU. WB_ALU: reg_we=1 -> FETCH.
- BR_CALC: pc_sel=01, alu_a_sel=1 -> BR_UPD.
- BR_UPD: pc_we = zero, or 1 if jst; for jst also pop=1 and pc_sel=11, otherwise pc_sel=10 -> FETCH.
- JMP: pc_we=1, alu_op=11, alu_b_sel=11; jal also push=1 -> FETCH.
- IN_WAIT: in_ready=1, in_sel=1, reg_we = in_valid. Exits on in_valid (transfer cycle) -> FETCH.
- OUT_WAIT: out_valid=1. Exits on out_ready -> FETCH.
- Handshake timeout: when IO_TIMEOUT>0 and the counter reaches IO_TIMEOUT-1 without the handshake, io_timeout pulses 1 cycle, no register write occurs, -> FETCH. If the handshake and the limit fall in the same cycle, the handshake wins and there is no timeout.
- STK_RD: stk_sel=1, alu_a_sel=1 -> STK_PUSH (push=1) -> FETCH.
- STK_LD: addr_sel=1, wdata_sel=1 -> MEM_WR, then STK_POP (pop=1, reg_we=0) -> FETCH.
- HALT: halted=1; all enables 0; stays until resume=1 -> FETCH. PC was not incremented in DECODE, so after resume the hlt is refetched unless the PC is externally changed. That refetch is the intended single-step behaviour.
- Counter: clears on every state change and saturates; width is ceil(log2(max(MEM_LAT, IO_TIMEOUT)+2)).
- Reset mid-operation: wins over all transitions. It aborts any handshake or memory wait with no partial write.
- Undefined state encodings -> FETCH.

Decomposition:
- Package ctrl_pkg:
  - opcode constants (R=0, addi=1 … hlt=0x12, in=0x13, out=0x14, jmp=0x15, jal=0x16, jst=0x17, lstk=0x1C, sstk=0x1D);
  - state enum;
  - pc_sel, alu_b_sel and alu_op encodings.
- One sub-module, ctrl_wait_cnt: the clearable saturating counter with a terminal-count compare shared by the memory and I/O waits.

Test Plan:
- add R-type, MEM_LAT=1 → states FETCH, DECODE, EXEC_R, WB_ALU, FETCH; reg_we=1 only in WB_ALU.
- ldi with MEM_LAT=3 → MEM_RD held 4 cycles, then reg_we=1 for exactly 1 cycle.
- in with IO_TIMEOUT=0; in_valid asserted after 20 cycles → in_ready held 20 cycles; reg_we pulses on the transfer cycle; next state FETCH.
- out with IO_TIMEOUT=8, out_ready never asserted → io_timeout pulses at the 8th OUT_WAIT cycle; no write enable asserted; return to FETCH.
- beq with zero=0, then zero=1 → pc_we=0, then pc_we=1 with pc_sel=10 in BR_UPD.
- hlt, then resume after 5 cycles → halted high for 5 cycles, PC not written; reset asserted in IN_WAIT → next state FETCH with in_ready=0.
